// File: rtl/fft_result_reader.sv
// Avalon-MM read port onto the FFT result SRAM: 256 samples, optional status word at 256.
// Define FFT_RD_STATUS_EN to expose the status register; otherwise address 256 reads as unmapped.
module fft_result_reader #(
  parameter int SRAM_LAT = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        slave_read_i,
  input  logic        slave_chipselect_i,
  input  logic [8:0]  slave_address_i,
  output logic [15:0] slave_readdata_o,
  output logic        slave_readdatavalid_o,
  output logic        slave_waitrequest_o,
  input  logic        fft_done_i,
  output logic [8:0]  sram_raddr_o,
  output logic        sram_ren_o,
  input  logic [15:0] sram_rdata_i,
  output logic        result_ack_o
);

  typedef enum logic [2:0] {WAIT_DONE, READY, FETCH, RESPOND, ACK} state_e;

  localparam logic [1:0] WAIT_LAST = 2'(SRAM_LAT - 1);

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic [15:0] readdata_q, readdata_d;
  logic        rvalid_q, rvalid_d;
  logic        ren_q, ren_d;
  logic [8:0]  raddr_q, raddr_d;

  logic acc, is_sample, is_status;

  assign slave_waitrequest_o   = (state_q == FETCH) || (state_q == RESPOND);
  assign acc                   = slave_read_i & slave_chipselect_i & ~slave_waitrequest_o;
  assign is_sample             = ~slave_address_i[8];
`ifdef FFT_RD_STATUS_EN
  assign is_status             = (slave_address_i == 9'd256);
`else
  assign is_status             = 1'b0;
`endif
  assign slave_readdata_o      = readdata_q;
  assign slave_readdatavalid_o = rvalid_q;
  assign sram_raddr_o          = raddr_q;
  assign sram_ren_o            = ren_q;
  assign result_ack_o          = (state_q == ACK);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= WAIT_DONE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      wcnt_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      readdata_q  <= '0;
      rvalid_q    <= 1'b0;
      ren_q       <= 1'b0;
      raddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      wcnt_q      <= wcnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      readdata_q  <= readdata_d;
      rvalid_q    <= rvalid_d;
      ren_q       <= ren_d;
      raddr_q     <= raddr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    wcnt_d      = wcnt_q;
    pend_vld_d  = 1'b0;
    pend_data_d = pend_data_q;
    readdata_d  = readdata_q;
    rvalid_d    = 1'b0;
    ren_d       = 1'b0;
    raddr_d     = raddr_q;

    // Non-SRAM answers are staged one cycle so they share the 1-edge latency slot
    if (pend_vld_q) begin
      readdata_d = pend_data_q;
      rvalid_d   = 1'b1;
    end

    case (state_q)
      WAIT_DONE: if (fft_done_i) state_d = READY;
      READY: begin
        if (acc && is_sample) begin
          state_d = FETCH;
          ren_d   = 1'b1;
          raddr_d = slave_address_i;
          cnt_d   = cnt_q + 9'd1;
          wcnt_d  = '0;
        end
      end
      FETCH: begin
        if (wcnt_q == WAIT_LAST) state_d = RESPOND;
        else                     wcnt_d  = wcnt_q + 2'd1;
      end
      RESPOND: begin
        readdata_d = sram_rdata_i;
        rvalid_d   = 1'b1;
        state_d    = (cnt_q == 9'd256) ? ACK : READY;
      end
      ACK: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      default: state_d = WAIT_DONE;
    endcase

    if (acc && !(state_q == READY && is_sample)) begin
      pend_vld_d = 1'b1;
      if (is_status) begin
        pend_data_d = {err_q, 5'b0, cnt_q, state_q == READY};
        err_d       = 1'b0;
      end else begin
        pend_data_d = '0;
        err_d       = 1'b1;
      end
    end

    // Overrun wins over a same-edge status clear: it is a newer event than the snapshot
    if (fft_done_i && state_q != WAIT_DONE) err_d = 1'b1;
  end

endmodule

// File: doc/fft_result_reader.md
FFT_RESULT_READER -- requirements
Module: fft_result_reader

Interface
REQ-001 Parameter: SRAM_LAT, default 1, SRAM read latency in clock edges from sram_ren sampled high to sram_rdata valid; legal range 1..4.
REQ-002 clk  input  1  clock, rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 slave_read  input  1  Avalon-MM read strobe.
REQ-005 slave_chipselect  input  1  Avalon-MM chipselect.
REQ-006 slave_address  input  9  word address: 0..255 FFT result samples, 256 status register, 257..511 unmapped.
REQ-007 slave_readdata  output  16  read response data.
REQ-008 slave_readdatavalid  output  1  one-cycle strobe qualifying slave_readdata.
REQ-009 slave_waitrequest  output  1  high while a read is in flight; host holds the request.
REQ-010 fft_done  input  1  one-cycle pulse: FFT results present in SRAM.
REQ-011 sram_raddr  output  9  SRAM read address.
REQ-012 sram_ren  output  1  SRAM read enable, one cycle per fetch.
REQ-013 sram_rdata  input  16  SRAM read data.
REQ-014 result_ack  output  1  one-cycle pulse: all 256 results consumed.

Function
REQ-015 States: WAIT_DONE, READY, FETCH, RESPOND, ACK.
REQ-016 Accept: a read is accepted on a rising edge with slave_read=1, slave_chipselect=1, slave_waitrequest=0.
REQ-017 slave_waitrequest = 1 in FETCH and RESPOND; 0 in WAIT_DONE, READY, ACK.
REQ-018 WAIT_DONE -> READY on the edge sampling fft_done=1.
REQ-019 READY, accepted address 0..255 -> FETCH; sram_raddr = accepted address and sram_ren = 1 for exactly the cycle after the accept edge.
REQ-020 FETCH waits SRAM_LAT edges after sram_ren is sampled, then captures sram_rdata into slave_readdata -> RESPOND.
REQ-021 RESPOND: slave_readdatavalid = 1 for one cycle; total latency is SRAM_LAT+1 edges from the accept edge; then -> READY, or -> ACK if the sample count reached 256.
REQ-022 Sample count: 9 bits; increments once per accepted sample read in READY, including repeated addresses; no address-uniqueness check.
REQ-023 ACK: result_ack = 1 for one cycle; count cleared to 0; -> WAIT_DONE.
REQ-024 Status read (address 256), any state that accepts: no SRAM access; slave_readdata = {err, 5'b0, count[8:0], ready} with readdatavalid 1 edge after accept; err cleared on the same edge.
REQ-025 Sample read accepted in WAIT_DONE: no SRAM access; readdata 16'h0000, valid 1 edge after accept; err set.
REQ-026 Unmapped read (257..511): no SRAM access; readdata 16'h0000, valid 1 edge after accept; err set.
REQ-027 fft_done while not in WAIT_DONE: ignored for state; err set (overrun).
REQ-028 Accept and fft_done on the same edge in WAIT_DONE: the read is handled per REQ-025, then -> READY.
REQ-029 slave_readdata holds its last value when readdatavalid = 0.
REQ-030 sram_ren is never asserted outside REQ-019.

Reset
REQ-031 On n_rst = 0: state WAIT_DONE, count 0, err 0, slave_readdata 0, slave_readdatavalid 0, sram_ren 0, sram_raddr 0, result_ack 0; slave_waitrequest 0 (follows from WAIT_DONE).
REQ-032 Reset mid-fetch drops the pending response; no readdatavalid is issued after reset is released.

Configuration
REQ-033 Macro FFT_RD_STATUS_EN: when defined, address 256 behaves per REQ-024.
REQ-034 When FFT_RD_STATUS_EN is not defined, address 256 is treated as unmapped per REQ-026, and err is internal only.

Verification
REQ-035 Reset, then a sample read at address 5 -> readdata 0x0000, valid 1 edge after accept, no sram_ren; status read returns 0x8000.
REQ-036 fft_done pulse, then read address 7 with SRAM_LAT=1 and SRAM word 7 = 0x1234 -> sram_ren with raddr 7 on the cycle after accept; readdatavalid with 0x1234 2 edges after accept; waitrequest high for 2 cycles.
REQ-037 fft_done, then 256 sequential reads -> result_ack pulses once after the 256th response; next status read returns 0x0000.
REQ-038 fft_done, then 10 reads, then a status read -> readdata 0x0015 (count 10, ready 1).
REQ-039 Read address 300 in READY -> readdata 0x0000; status then shows err (bit 15) set; a second status read shows it cleared.
REQ-040 Assert n_rst during FETCH -> no readdatavalid; state WAIT_DONE; status read returns 0x0000.
